// File: rtl/ps2_mouse_rx.sv
// PS/2 mouse receiver: synchronizes and de-glitches the PS/2 lines, deframes
// 11-bit serial frames and assembles 3-byte movement packets. The packet bus
// only updates on a complete packet; bit 24 toggles on every update.
//
// state | meaning
// IDLE  | waiting for a start bit (falling clock edge with data low)
// RECV  | shifting in 8 data bits, parity and stop bit
`timescale 1ns/1ps
module ps2_mouse_rx #(
  parameter int FILT_LEN    = 8,
  parameter int BIT_TIMEOUT = 6000,
  parameter int PKT_TIMEOUT = 1000000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [24:0] ps2_mouse,
  output logic        frame_err
);

  localparam int FILT_W = $clog2(FILT_LEN + 1);
  localparam int BIT_W  = $clog2(BIT_TIMEOUT + 1);
  localparam int PKT_W  = $clog2(PKT_TIMEOUT + 1);
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILT_LEN - 1);
  localparam logic [BIT_W-1:0]  BIT_LOAD  = BIT_W'(BIT_TIMEOUT);
  localparam logic [PKT_W-1:0]  PKT_LOAD  = PKT_W'(PKT_TIMEOUT);

  typedef enum logic {IDLE, RECV} state_t;

  logic              clk_s1, clk_s2, data_s1, data_s2;
  logic [FILT_W-1:0] filt_cnt;
  logic              filt_clk, filt_clk_q;
  logic              bit_evt;
  state_t            state, state_nxt;
  logic [3:0]        bit_cnt;
  logic [8:0]        shreg;
  logic [BIT_W-1:0]  bit_tmr;
  logic [PKT_W-1:0]  pkt_tmr;
  logic [1:0]        pkt_idx;
  logic [7:0]        status_b, x_b;
  logic              start_err, frame_ok, frame_bad, bit_to, shift_en;
  logic              status_rej, pkt_to;

  // Two-flop synchronizers; idle line level is high.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      clk_s1  <= ps2_clk;
      clk_s2  <= clk_s1;
      data_s1 <= ps2_data;
      data_s2 <= data_s1;
    end
  end

  // Clock filter: a new level is accepted after FILT_LEN consecutive samples.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      filt_cnt   <= '0;
      filt_clk   <= 1'b1;
      filt_clk_q <= 1'b1;
    end else begin
      filt_clk_q <= filt_clk;
      if (clk_s2 == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_LAST) begin
        filt_cnt <= '0;
        filt_clk <= clk_s2;
      end else begin
        filt_cnt <= filt_cnt + FILT_W'(1);
      end
    end
  end

  assign bit_evt = filt_clk_q & ~filt_clk;

  // Frame FSM state register.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Frame FSM next state and per-cycle frame events.
  always_comb begin
    state_nxt = state;
    start_err = 1'b0;
    frame_ok  = 1'b0;
    frame_bad = 1'b0;
    bit_to    = 1'b0;
    shift_en  = 1'b0;
    case (state)
      IDLE: begin
        if (bit_evt) begin
          if (!data_s2) state_nxt = RECV;
          else          start_err = 1'b1;
        end
      end
      RECV: begin
        if (bit_evt) begin
          if (bit_cnt == 4'd9) begin
            state_nxt = IDLE;
            // shreg holds 8 data bits plus parity: odd parity means XOR = 1
            if ((^shreg) && data_s2) frame_ok  = 1'b1;
            else                     frame_bad = 1'b1;
          end else begin
            shift_en = 1'b1;
          end
        end else if (bit_tmr == '0) begin
          bit_to    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Frame datapath: bit counter, LSB-first shift register, bit timer.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      bit_cnt <= '0;
      shreg   <= '0;
      bit_tmr <= '0;
    end else begin
      if (state == IDLE) begin
        bit_cnt <= '0;
        shreg   <= '0;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + 4'd1;
        shreg   <= {data_s2, shreg[8:1]};
      end
      if (bit_evt || state == IDLE) bit_tmr <= BIT_LOAD;
      else if (bit_tmr != '0)       bit_tmr <= bit_tmr - BIT_W'(1);
    end
  end

  assign status_rej = frame_ok && (pkt_idx == 2'd0) && !shreg[3];
  assign pkt_to     = (pkt_idx != 2'd0) && (pkt_tmr == '0) && !bit_evt;

  // Packet assembler: status, X, Y; the output bus loads only on Y.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      pkt_idx   <= '0;
      status_b  <= '0;
      x_b       <= '0;
      ps2_mouse <= '0;
      pkt_tmr   <= '0;
    end else begin
      if (frame_ok || bit_evt) pkt_tmr <= PKT_LOAD;
      else if (pkt_tmr != '0)  pkt_tmr <= pkt_tmr - PKT_W'(1);
      if (frame_bad || bit_to) begin
        pkt_idx <= 2'd0;
      end else if (frame_ok) begin
        case (pkt_idx)
          2'd0: begin
            if (shreg[3]) begin
              status_b <= shreg[7:0];
              pkt_idx  <= 2'd1;
            end
          end
          2'd1: begin
            x_b     <= shreg[7:0];
            pkt_idx <= 2'd2;
          end
          2'd2: begin
            ps2_mouse <= {~ps2_mouse[24], shreg[7:0], x_b, status_b};
            pkt_idx   <= 2'd0;
          end
          default: pkt_idx <= 2'd0;
        endcase
      end else if (pkt_to) begin
        pkt_idx <= 2'd0;
      end
    end
  end

  // Single registered error pulse merging all causes.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) frame_err <= 1'b0;
    else       frame_err <= start_err | frame_bad | bit_to | status_rej;
  end

endmodule

// File: tb/tb_ps2_mouse_rx.sv
// Bench for ps2_mouse_rx: table of packets driven as PS/2 frames, a scoreboard
// queue of expected packet-bus values, and hand sequences for timing corners.
`timescale 1ns/1ps
module tb_ps2_mouse_rx;
  localparam int FILT_LEN    = 8;
  localparam int BIT_TIMEOUT = 200;
  localparam int PKT_TIMEOUT = 2000;
  localparam int HALF        = 20;
  localparam int GAP         = 60;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [24:0] ps2_mouse;
  logic        frame_err;

  int errors = 0, checks = 0, cyc = 0, err_seen = 0, stop_fall_cyc = 0;
  logic [24:0] sb[$];
  logic        exp_tog = 1'b0;
  logic [24:0] prev = '0;
  logic        prev_err = 1'b0;

  typedef struct {
    int          n;
    logic [31:0] b;
    logic [3:0]  bad_par;
    logic [3:0]  bad_stop;
    int          post_wait;
    int          exp_err;
    bit          exp_upd;
    logic [23:0] exp_word;
  } vec_t;

  vec_t vecs[8];

  ps2_mouse_rx #(.FILT_LEN(FILT_LEN), .BIT_TIMEOUT(BIT_TIMEOUT), .PKT_TIMEOUT(PKT_TIMEOUT)) dut (
    .clk_sys(clk_sys), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .ps2_mouse(ps2_mouse), .frame_err(frame_err));

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc++;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic send_bit(logic v);
    ps2_data = v;
    tick(HALF);
    ps2_clk = 1'b0;
    stop_fall_cyc = cyc;
    tick(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_byte(logic [7:0] b, logic bad_par, logic bad_stop);
    logic par;
    par = ~(^b) ^ bad_par;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(par);
    send_bit(~bad_stop);
    ps2_data = 1'b1;
    tick(GAP);
  endtask

  function automatic vec_t mk(int n, logic [31:0] b, logic [3:0] bp, logic [3:0] bs,
                              int pw, int ee, bit eu, logic [23:0] ew);
    vec_t v;
    v.n = n; v.b = b; v.bad_par = bp; v.bad_stop = bs;
    v.post_wait = pw; v.exp_err = ee; v.exp_upd = eu; v.exp_word = ew;
    return v;
  endfunction

  task automatic apply_row(int i);
    int   e0;
    vec_t v;
    v  = vecs[i];
    e0 = err_seen;
    for (int k = 0; k < v.n; k++) begin
      if (k == v.n - 1 && v.exp_upd) begin
        exp_tog = ~exp_tog;
        sb.push_back({exp_tog, v.exp_word});
      end
      send_byte(v.b[k*8 +: 8], v.bad_par[k], v.bad_stop[k]);
    end
    tick(v.post_wait);
    chk($sformatf("row%0d_err_pulses", i), err_seen - e0, v.exp_err);
    chk($sformatf("row%0d_pending", i), sb.size(), 0);
  endtask

  // Output monitor: counts error pulses, checks width, pops scoreboard on updates.
  always @(negedge clk_sys) begin
    if (reset) begin
      prev     = ps2_mouse;
      prev_err = 1'b0;
    end else begin
      if (frame_err && !prev_err) err_seen++;
      if (prev_err) chk("err_width", {31'd0, frame_err}, 32'd0);
      prev_err = frame_err;
      if (ps2_mouse !== prev) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_update: got %0h want %0h", ps2_mouse, prev);
        end else begin
          logic [24:0] e;
          int          lat;
          e   = sb.pop_front();
          lat = cyc - stop_fall_cyc;
          chk("packet", {7'd0, ps2_mouse}, {7'd0, e});
          chk("latency_ok", {31'd0, (lat >= FILT_LEN + 2) && (lat <= FILT_LEN + 4)}, 32'd1);
        end
        prev = ps2_mouse;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, fall;
    vecs[0] = mk(3, 32'h00FB0508, 4'b0000, 4'b0000, 0, 0, 1'b1, 24'hFB0508);
    vecs[1] = mk(3, 32'h00FB0508, 4'b0000, 4'b0000, 0, 0, 1'b1, 24'hFB0508);
    vecs[2] = mk(4, 32'h02010800, 4'b0000, 4'b0000, 0, 1, 1'b1, 24'h020108);
    vecs[3] = mk(3, 32'h00FB0508, 4'b0010, 4'b0000, PKT_TIMEOUT + 200, 1, 1'b0, 24'h0);
    vecs[4] = mk(3, 32'h00FB0508, 4'b0000, 4'b0000, 0, 0, 1'b1, 24'hFB0508);
    vecs[5] = mk(3, 32'h00807F09, 4'b0000, 4'b0000, 0, 0, 1'b1, 24'h807F09);
    vecs[6] = mk(3, 32'h00FF0018, 4'b0000, 4'b0000, 0, 0, 1'b1, 24'hFF0018);
    vecs[7] = mk(4, 32'h332208C8, 4'b0000, 4'b0001, 0, 1, 1'b1, 24'h332208);

    reset = 1'b1;
    tick(5);
    chk("reset_mouse", {7'd0, ps2_mouse}, 32'd0);
    chk("reset_err", {31'd0, frame_err}, 32'd0);
    reset = 1'b0;
    tick(10);

    for (int i = 0; i < 8; i++) apply_row(i);

    // Short low glitch with data high: a false bit event would raise frame_err.
    e0 = err_seen;
    ps2_clk = 1'b0;
    tick(3);
    ps2_clk = 1'b1;
    tick(40);
    chk("glitch_ignored", err_seen - e0, 0);

    // Real falling edge with data high in IDLE is a bad start bit.
    e0 = err_seen;
    ps2_clk = 1'b0;
    tick(HALF);
    ps2_clk = 1'b1;
    tick(HALF);
    chk("bad_start", err_seen - e0, 1);

    // Abandon a frame after four bits; the timeout must not fire early.
    e0 = err_seen;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    ps2_data = 1'b1;
    fall = stop_fall_cyc;
    while (cyc < fall + BIT_TIMEOUT) tick(1);
    chk("bit_timeout_early", err_seen - e0, 0);
    tick(60);
    chk("bit_timeout", err_seen - e0, 1);
    apply_row(0);

    // Reset after the status byte discards the partial packet.
    send_byte(8'h08, 1'b0, 1'b0);
    reset = 1'b1;
    tick(3);
    chk("midreset_mouse", {7'd0, ps2_mouse}, 32'd0);
    chk("midreset_err", {31'd0, frame_err}, 32'd0);
    exp_tog = 1'b0;
    reset = 1'b0;
    tick(5);
    e0 = err_seen;
    send_byte(8'h05, 1'b0, 1'b0);
    send_byte(8'hFB, 1'b0, 1'b0);
    chk("postreset_err", err_seen - e0, 1);
    chk("postreset_mouse", {7'd0, ps2_mouse}, 32'd0);
    tick(PKT_TIMEOUT + 200);
    apply_row(5);

    tick(20);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
